// File: rtl/alu_pkg.sv
// Shared types and constants for the sliced sequential ALU.
// Command codes match the combinational ALU; command[0] doubles as the subtract select.
package alu_pkg;

  typedef logic [2:0] alu_cmd_t;

  localparam alu_cmd_t ALU_ADD  = 3'd0;
  localparam alu_cmd_t ALU_SUB  = 3'd1;
  localparam alu_cmd_t ALU_XOR  = 3'd2;
  localparam alu_cmd_t ALU_SLT  = 3'd3;
  localparam alu_cmd_t ALU_AND  = 3'd4;
  localparam alu_cmd_t ALU_NAND = 3'd5;
  localparam alu_cmd_t ALU_NOR  = 3'd6;
  localparam alu_cmd_t ALU_OR   = 3'd7;

  typedef enum logic [1:0] {IDLE, RUN, DONE} alu_state_e;

  // Logic commands report carryout and overflow as 0.
  function automatic logic is_logic_cmd(input alu_cmd_t c);
    return !(c == ALU_ADD || c == ALU_SUB || c == ALU_SLT);
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Operand/result handshake bundle for alu_seq.
interface alu_seq_if import alu_pkg::*; #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  alu_cmd_t         command;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carryout;
  logic             overflow;
  logic             zero;

  modport master (
    output in_valid, a, b, command, out_ready,
    input  in_ready, out_valid, result, carryout, overflow, zero
  );

  modport slave (
    input  in_valid, a, b, command, out_ready,
    output in_ready, out_valid, result, carryout, overflow, zero
  );
endinterface

// File: rtl/alu_slice.sv
// Combinational SLICE-bit ALU unit: ripple adder with B inversion plus bitwise ops.
module alu_slice import alu_pkg::*; #(
  parameter int unsigned SLICE = 8
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  input  alu_cmd_t         command,
  output logic [SLICE-1:0] res,
  output logic             cout,
  output logic             msb_cin
);
  logic [SLICE-1:0] bx;
  logic [SLICE-1:0] sum;

  assign bx = b ^ {SLICE{command[0]}};

  always_comb begin
    logic c;
    c       = cin;
    msb_cin = 1'b0;
    sum     = '0;
    for (int unsigned i = 0; i < SLICE; i++) begin
      if (i == SLICE - 1) msb_cin = c;
      sum[i] = a[i] ^ bx[i] ^ c;
      c      = (a[i] & bx[i]) | (c & (a[i] ^ bx[i]));
    end
    cout = c;
  end

  // Bitwise ops use the uninverted b.
  always_comb begin
    res = sum;
    unique case (command)
      ALU_XOR:  res = a ^ b;
      ALU_AND:  res = a & b;
      ALU_NAND: res = ~(a & b);
      ALU_NOR:  res = ~(a | b);
      ALU_OR:   res = a | b;
      default:  res = sum;
    endcase
  end
endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU: one SLICE-bit chunk per clock through a shared alu_slice,
// with the inter-slice carry held in a register and a valid/ready handshake.
module alu_seq import alu_pkg::*; #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SLICE = 8
) (
  input logic      clk,
  input logic      rst_n,
  alu_seq_if.slave bus
);
  localparam int unsigned NSLICE = WIDTH / SLICE;
  localparam int unsigned IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

  alu_state_e       state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q;
  alu_cmd_t         cmd_q;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d;

  logic [SLICE-1:0] sl_a, sl_b, sl_res;
  logic             sl_cout, sl_msb_cin;
  logic             accept;

  assign accept = (state_q == IDLE) && bus.in_valid;

  always_comb begin
    sl_a = '0;
    sl_b = '0;
    for (int unsigned k = 0; k < NSLICE; k++) begin
      if (idx_q == IDXW'(k)) begin
        sl_a = a_q[k*SLICE +: SLICE];
        sl_b = b_q[k*SLICE +: SLICE];
      end
    end
  end

  alu_slice #(.SLICE(SLICE)) u_slice (
    .a       (sl_a),
    .b       (sl_b),
    .cin     (carry_q),
    .command (cmd_q),
    .res     (sl_res),
    .cout    (sl_cout),
    .msb_cin (sl_msb_cin)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          state_d = RUN;
          idx_d   = '0;
          carry_d = bus.command[0];
        end
      end
      RUN: begin
        carry_d = sl_cout;
        if (cmd_q != ALU_SLT) begin
          for (int unsigned k = 0; k < NSLICE; k++) begin
            if (idx_q == IDXW'(k)) result_d[k*SLICE +: SLICE] = sl_res;
          end
        end
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
          if (is_logic_cmd(cmd_q)) begin
            cout_d = 1'b0;
            ovf_d  = 1'b0;
          end else begin
            cout_d = sl_cout;
            ovf_d  = sl_msb_cin ^ sl_cout;
          end
          // SLT: sign of the difference corrected by overflow.
          if (cmd_q == ALU_SLT) begin
            result_d    = '0;
            result_d[0] = sl_msb_cin ^ sl_cout ^ sl_res[SLICE-1];
          end
          zero_d = ~|result_d;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      cmd_q    <= ALU_ADD;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
      if (accept) begin
        a_q   <= bus.a;
        b_q   <= bus.b;
        cmd_q <= bus.command;
      end
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.result    = result_q;
  assign bus.carryout  = cout_q;
  assign bus.overflow  = ovf_q;
  assign bus.zero      = zero_q;
endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: a 32/8 instance and a 16/16 instance sharing clock and reset.
module tb_alu_seq;
  import alu_pkg::*;

  logic clk;
  logic rst_n;
  int   compared;
  int   mismatched;
  int   lat;

  alu_seq_if #(.WIDTH(32)) bus32 ();
  alu_seq_if #(.WIDTH(16)) bus16 ();

  alu_seq #(.WIDTH(32), .SLICE(8)) u_dut32 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus32)
  );

  alu_seq #(.WIDTH(16), .SLICE(16)) u_dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present an op on the 32-bit bus and count negedges until out_valid (bounded).
  task automatic op32(input alu_cmd_t cmd, input logic [31:0] a, input logic [31:0] b,
                      output int n);
    @(negedge clk);
    check("in_ready_pre32", bus32.in_ready, 1);
    bus32.in_valid = 1'b1;
    bus32.command  = cmd;
    bus32.a        = a;
    bus32.b        = b;
    @(negedge clk);
    bus32.in_valid = 1'b0;
    n = 0;
    while (!bus32.out_valid && n < 64) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic op16(input alu_cmd_t cmd, input logic [15:0] a, input logic [15:0] b,
                      output int n);
    @(negedge clk);
    check("in_ready_pre16", bus16.in_ready, 1);
    bus16.in_valid = 1'b1;
    bus16.command  = cmd;
    bus16.a        = a;
    bus16.b        = b;
    @(negedge clk);
    bus16.in_valid = 1'b0;
    n = 0;
    while (!bus16.out_valid && n < 64) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic pop32();
    bus32.out_ready = 1'b1;
    @(negedge clk);
    bus32.out_ready = 1'b0;
  endtask

  task automatic pop16();
    bus16.out_ready = 1'b1;
    @(negedge clk);
    bus16.out_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    compared   = 0;
    mismatched = 0;
    rst_n      = 1'b0;
    bus32.in_valid = 1'b0; bus32.a = '0; bus32.b = '0; bus32.command = ALU_ADD;
    bus32.out_ready = 1'b0;
    bus16.in_valid = 1'b0; bus16.a = '0; bus16.b = '0; bus16.command = ALU_ADD;
    bus16.out_ready = 1'b0;

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", bus32.in_ready, 1);
    check("rst_out_valid", bus32.out_valid, 0);
    check("rst_result", bus32.result, 0);
    check("rst_flags", {bus32.carryout, bus32.overflow, bus32.zero}, 0);

    // ADD wrap to zero
    op32(ALU_ADD, 32'hFFFF_FFFF, 32'h0000_0001, lat);
    check("add_latency", lat, 4);
    check("add_result", bus32.result, 32'h0000_0000);
    check("add_carry", bus32.carryout, 1);
    check("add_ovf", bus32.overflow, 0);
    check("add_zero", bus32.zero, 1);
    pop32();

    // SUB with signed overflow
    op32(ALU_SUB, 32'h8000_0000, 32'h0000_0001, lat);
    check("sub_result", bus32.result, 32'h7FFF_FFFF);
    check("sub_ovf", bus32.overflow, 1);
    check("sub_carry", bus32.carryout, 1);
    check("sub_zero", bus32.zero, 0);
    pop32();

    op32(ALU_SLT, 32'hFFFF_FFFB, 32'h0000_0003, lat);
    check("slt_neg_result", bus32.result, 32'h0000_0001);
    check("slt_neg_zero", bus32.zero, 0);
    pop32();

    op32(ALU_SLT, 32'h7FFF_FFFF, 32'h8000_0000, lat);
    check("slt_ovf_result", bus32.result, 32'h0000_0000);
    check("slt_ovf_zero", bus32.zero, 1);
    pop32();

    op32(ALU_NAND, 32'hF0F0_F0F0, 32'hFF00_FF00, lat);
    check("nand_result", bus32.result, 32'h0FFF_0FFF);
    check("nand_carry", bus32.carryout, 0);
    check("nand_ovf", bus32.overflow, 0);
    pop32();

    op32(ALU_XOR, 32'h1234_5678, 32'hFFFF_0000, lat);
    check("xor_result", bus32.result, 32'hEDCB_5678);
    pop32();

    op32(ALU_NOR, 32'h0000_00FF, 32'h00FF_0000, lat);
    check("nor_result", bus32.result, 32'hFF00_FF00);
    pop32();

    op32(ALU_OR, 32'hFFFF_FFFF, 32'h0000_0000, lat);
    check("or_result", bus32.result, 32'hFFFF_FFFF);
    check("or_carry", bus32.carryout, 0);
    pop32();

    // Backpressure: hold DONE, offer a second op that must be ignored
    op32(ALU_ADD, 32'd1, 32'd2, lat);
    check("bp_result0", bus32.result, 32'd3);
    bus32.in_valid = 1'b1;
    bus32.command  = ALU_ADD;
    bus32.a        = 32'd10;
    bus32.b        = 32'd20;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_out_valid", bus32.out_valid, 1);
      check("bp_in_ready", bus32.in_ready, 0);
      check("bp_result", bus32.result, 32'd3);
      check("bp_flags", {bus32.carryout, bus32.overflow, bus32.zero}, 3'b000);
    end
    bus32.out_ready = 1'b1;
    @(negedge clk);
    bus32.out_ready = 1'b0;
    check("bp_idle_ready", bus32.in_ready, 1);
    @(negedge clk);
    bus32.in_valid = 1'b0;
    lat = 0;
    while (!bus32.out_valid && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    check("bp_second_latency", lat, 4);
    check("bp_second_result", bus32.result, 32'd30);
    pop32();

    // Reset during the second RUN cycle
    @(negedge clk);
    bus32.in_valid = 1'b1;
    bus32.command  = ALU_ADD;
    bus32.a        = 32'h1111_1111;
    bus32.b        = 32'h2222_2222;
    @(negedge clk);
    bus32.in_valid = 1'b0;
    @(negedge clk);
    check("mid_partial", bus32.result[7:0], 8'h33);
    rst_n = 1'b0;
    #1;
    check("mid_rst_result", bus32.result, 0);
    check("mid_rst_flags", {bus32.carryout, bus32.overflow, bus32.zero}, 0);
    check("mid_rst_out_valid", bus32.out_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("mid_rel_in_ready", bus32.in_ready, 1);
    op32(ALU_ADD, 32'd3, 32'd4, lat);
    check("post_rst_latency", lat, 4);
    check("post_rst_result", bus32.result, 32'd7);
    pop32();

    // Single-slice configuration
    op16(ALU_ADD, 16'h7FFF, 16'h0001, lat);
    check("w16_latency", lat, 1);
    check("w16_result", bus16.result, 16'h8000);
    check("w16_ovf", bus16.overflow, 1);
    check("w16_carry", bus16.carryout, 0);
    check("w16_zero", bus16.zero, 0);
    pop16();

    op16(ALU_SUB, 16'h0005, 16'h0005, lat);
    check("w16_sub_result", bus16.result, 16'h0000);
    check("w16_sub_zero", bus16.zero, 1);
    check("w16_sub_carry", bus16.carryout, 1);
    check("w16_sub_ovf", bus16.overflow, 0);
    pop16();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
